// File: rtl/trdb_packet_if.sv
// Retirement-side inputs and packet-request outputs of the trace packet scheduler.
// The master side is the tracer/emitter; the slave side is the scheduler.
interface trdb_packet_if #(
    parameter int XLEN     = 32,
    parameter int BMAP_LEN = 31
);
    logic                enable_i;
    logic                inst_valid_i;
    logic [XLEN-1:0]     iaddr_i;
    logic                is_branch_i;
    logic                branch_taken_i;
    logic                exception_i;
    logic                interrupt_i;
    logic                updiscon_i;
    logic                packet_ready_i;
    logic                packet_valid_o;
    logic [1:0]          format_o;
    logic [1:0]          subformat_o;
    logic [XLEN-1:0]     addr_o;
    logic [4:0]          branches_o;
    logic [BMAP_LEN-1:0] branch_map_o;
    logic                interrupt_o;
    logic                stall_o;

    modport master (
        output enable_i, inst_valid_i, iaddr_i, is_branch_i, branch_taken_i,
               exception_i, interrupt_i, updiscon_i, packet_ready_i,
        input  packet_valid_o, format_o, subformat_o, addr_o, branches_o,
               branch_map_o, interrupt_o, stall_o
    );

    modport slave (
        input  enable_i, inst_valid_i, iaddr_i, is_branch_i, branch_taken_i,
               exception_i, interrupt_i, updiscon_i, packet_ready_i,
        output packet_valid_o, format_o, subformat_o, addr_o, branches_o,
               branch_map_o, interrupt_o, stall_o
    );
endinterface

// File: rtl/trdb_packet_scheduler.sv
// Trace packet scheduler: tracks the branch map and decides when to request a packet.
// Optional periodic resync enabled by defining TRDB_RESYNC_TIMER_EN.
module trdb_packet_scheduler #(
    parameter int XLEN       = 32,
    parameter int BMAP_LEN   = 31,
    parameter int RESYNC_MAX = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    trdb_packet_if.slave    bus
);
    localparam logic [1:0] F_OPT_EXT    = 2'd0;
    localparam logic [1:0] F_DIFF_DELTA = 2'd1;
    localparam logic [1:0] F_ADDR_ONLY  = 2'd2;
    localparam logic [1:0] F_SYNC       = 2'd3;
    localparam logic [1:0] SF_START     = 2'd0;
    localparam logic [1:0] SF_TRAP      = 2'd1;
    localparam logic [1:0] SF_SUPPORT   = 2'd3;
    localparam logic [4:0] MAP_FULL     = 5'(BMAP_LEN);

    typedef enum logic [2:0] {IDLE, SUPPORT, START, RUN, HOLD} state_e;

    state_e              state_q, state_d, ret_q, ret_d;
    logic                enable_q;
    logic [BMAP_LEN-1:0] map_q, map_d, map_app;
    logic [4:0]          cnt_q, cnt_d, cnt_app;
    logic                load;
    logic [1:0]          fmt_d, sub_d;
    logic [XLEN-1:0]     addr_d;
    logic [4:0]          br_d;
    logic [BMAP_LEN-1:0] bmap_d;
    logic                resync_pend;

    logic [1:0]          fmt_q, sub_q;
    logic [XLEN-1:0]     addr_q;
    logic [4:0]          br_q;
    logic [BMAP_LEN-1:0] bmap_q;
    logic                irq_q;

    // Current instruction's branch outcome joins the map before any snapshot
    always_comb begin
        map_app = map_q;
        cnt_app = cnt_q;
        if (bus.is_branch_i && cnt_q < MAP_FULL) begin
            map_app[cnt_q] = ~bus.branch_taken_i;
            cnt_app        = cnt_q + 5'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        map_d   = map_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        fmt_d   = F_OPT_EXT;
        sub_d   = SF_START;
        addr_d  = bus.iaddr_i;
        br_d    = '0;
        bmap_d  = '0;
        case (state_q)
            IDLE: begin
                map_d = '0;
                cnt_d = '0;
                if (bus.enable_i && !enable_q) state_d = SUPPORT;
            end
            SUPPORT: begin
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    fmt_d   = F_SYNC;
                    sub_d   = SF_SUPPORT;
                    addr_d  = '0;
                    ret_d   = START;
                    state_d = HOLD;
                end
            end
            START: begin
                map_d = '0;
                cnt_d = '0;
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (bus.inst_valid_i) begin
                    load    = 1'b1;
                    fmt_d   = F_SYNC;
                    sub_d   = SF_START;
                    ret_d   = RUN;
                    state_d = HOLD;
                end
            end
            RUN: begin
                if (!bus.enable_i) begin
                    map_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.inst_valid_i) begin
                    map_d  = map_app;
                    cnt_d  = cnt_app;
                    br_d   = cnt_app;
                    bmap_d = map_app;
                    load   = 1'b1;
                    if (bus.exception_i) begin
                        fmt_d = F_SYNC;
                        sub_d = SF_TRAP;
                    end else if (resync_pend) begin
                        fmt_d = F_SYNC;
                        sub_d = SF_START;
                    end else if (bus.updiscon_i) begin
                        fmt_d = (cnt_app != 5'd0) ? F_DIFF_DELTA : F_ADDR_ONLY;
                    end else if (cnt_app == MAP_FULL) begin
                        fmt_d = F_DIFF_DELTA;
                    end else begin
                        load = 1'b0;
                    end
                    if (load) begin
                        map_d   = '0;
                        cnt_d   = '0;
                        ret_d   = RUN;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // A disable during HOLD waits for the in-flight handshake to finish
                if (bus.packet_ready_i) state_d = bus.enable_i ? ret_q : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ret_q    <= START;
            enable_q <= 1'b0;
            map_q    <= '0;
            cnt_q    <= '0;
            fmt_q    <= '0;
            sub_q    <= '0;
            addr_q   <= '0;
            br_q     <= '0;
            bmap_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            enable_q <= bus.enable_i;
            map_q    <= map_d;
            cnt_q    <= cnt_d;
            if (load) begin
                fmt_q  <= fmt_d;
                sub_q  <= sub_d;
                addr_q <= addr_d;
                br_q   <= br_d;
                bmap_q <= bmap_d;
                irq_q  <= bus.interrupt_i;
            end
        end
    end

`ifdef TRDB_RESYNC_TIMER_EN
    localparam int RSW = $clog2(RESYNC_MAX + 1);
    localparam logic [RSW-1:0] RS_LAST = RSW'(RESYNC_MAX - 1);

    logic [RSW-1:0] rs_cnt_q;
    logic           rs_pend_q;
    logic           sync_clr, run_tick;

    assign sync_clr = load && fmt_d == F_SYNC && sub_d != SF_SUPPORT;
    assign run_tick = state_q == RUN && bus.inst_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rs_cnt_q  <= '0;
            rs_pend_q <= 1'b0;
        end else if (sync_clr || state_q == IDLE) begin
            rs_cnt_q  <= '0;
            rs_pend_q <= 1'b0;
        end else if (run_tick) begin
            if (rs_cnt_q >= RS_LAST) rs_pend_q <= 1'b1;
            else                     rs_cnt_q  <= rs_cnt_q + RSW'(1);
        end
    end

    assign resync_pend = rs_pend_q;
`else
    assign resync_pend = 1'b0;
`endif

    assign bus.packet_valid_o = (state_q == HOLD);
    assign bus.stall_o        = (state_q == HOLD);
    assign bus.format_o       = fmt_q;
    assign bus.subformat_o    = sub_q;
    assign bus.addr_o         = addr_q;
    assign bus.branches_o     = br_q;
    assign bus.branch_map_o   = bmap_q;
    assign bus.interrupt_o    = irq_q;
endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed bench for trdb_packet_scheduler with hand-computed expected packets.
module tb_trdb_packet_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    trdb_packet_if #(.XLEN(32), .BMAP_LEN(31)) bus ();

    trdb_packet_scheduler #(.XLEN(32), .BMAP_LEN(31), .RESYNC_MAX(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inst(input logic [31:0] a, input logic br, input logic tk,
                        input logic exc, input logic upd, input logic irq);
        bus.iaddr_i        = a;
        bus.is_branch_i    = br;
        bus.branch_taken_i = tk;
        bus.exception_i    = exc;
        bus.updiscon_i     = upd;
        bus.interrupt_i    = irq;
        bus.inst_valid_i   = 1'b1;
        step();
        bus.inst_valid_i   = 1'b0;
        bus.is_branch_i    = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.exception_i    = 1'b0;
        bus.updiscon_i     = 1'b0;
        bus.interrupt_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable_i       = 1'b0;
        bus.inst_valid_i   = 1'b0;
        bus.iaddr_i        = '0;
        bus.is_branch_i    = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.exception_i    = 1'b0;
        bus.interrupt_i    = 1'b0;
        bus.updiscon_i     = 1'b0;
        bus.packet_ready_i = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(bus.packet_valid_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_fmt", 32'(bus.format_o), 32'd0);
        chk("rst_sub", 32'(bus.subformat_o), 32'd0);
        chk("rst_addr", bus.addr_o, 32'd0);
        chk("rst_br", 32'(bus.branches_o), 32'd0);
        chk("rst_map", 32'(bus.branch_map_o), 32'd0);
        chk("rst_irq", 32'(bus.interrupt_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Instructions while disabled are ignored
        inst(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_nopkt", 32'(bus.packet_valid_o), 32'd0);

        // Enable: SUPPORT then START
        bus.enable_i = 1'b1;
        step();
        chk("sup_wait", 32'(bus.packet_valid_o), 32'd0);
        step();
        chk("sup_valid", 32'(bus.packet_valid_o), 32'd1);
        chk("sup_stall", 32'(bus.stall_o), 32'd1);
        chk("sup_fmt", 32'(bus.format_o), 32'd3);
        chk("sup_sub", 32'(bus.subformat_o), 32'd3);
        step();
        chk("sup_acc", 32'(bus.packet_valid_o), 32'd0);
        inst(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_valid", 32'(bus.packet_valid_o), 32'd1);
        chk("start_fmt", 32'(bus.format_o), 32'd3);
        chk("start_sub", 32'(bus.subformat_o), 32'd0);
        chk("start_addr", bus.addr_o, 32'h8000_0000);
        chk("start_br", 32'(bus.branches_o), 32'd0);
        step();

        // Periodic resync: only with the timer compiled in
        for (int i = 0; i < 8; i++) inst(32'h0000_0080 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rs_quiet", 32'(bus.packet_valid_o), 32'd0);
        inst(32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TRDB_RESYNC_TIMER_EN
        chk("rs_valid", 32'(bus.packet_valid_o), 32'd1);
        chk("rs_fmt", 32'(bus.format_o), 32'd3);
        chk("rs_sub", 32'(bus.subformat_o), 32'd0);
        chk("rs_addr", bus.addr_o, 32'h0000_0100);
        step();
`else
        chk("rs_none", 32'(bus.packet_valid_o), 32'd0);
`endif

        // 31 alternating branches, first taken: full map
        for (int i = 0; i < 31; i++) begin
            inst(32'h8000_1000 + 32'(i * 4), 1'b1, 1'(i % 2 == 0), 1'b0, 1'b0, 1'b0);
            if (i == 29) chk("full_quiet", 32'(bus.packet_valid_o), 32'd0);
        end
        chk("full_valid", 32'(bus.packet_valid_o), 32'd1);
        chk("full_fmt", 32'(bus.format_o), 32'd1);
        chk("full_br", 32'(bus.branches_o), 32'd31);
        chk("full_map", 32'(bus.branch_map_o), 32'h2AAA_AAAA);
        step();
        inst(32'h8000_0050, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ao_fmt", 32'(bus.format_o), 32'd2);
        chk("ao_br", 32'(bus.branches_o), 32'd0);
        chk("ao_addr", bus.addr_o, 32'h8000_0050);
        step();

        // Three branches, then a taken branch that is also an uninferable jump
        inst(32'h8000_00f0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        inst(32'h8000_00f4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        inst(32'h8000_00f8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        inst(32'h8000_0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("dd_fmt", 32'(bus.format_o), 32'd1);
        chk("dd_br", 32'(bus.branches_o), 32'd4);
        chk("dd_map", 32'(bus.branch_map_o), 32'h0000_0002);
        chk("dd_addr", bus.addr_o, 32'h8000_0100);
        step();

        // Trap with updiscon and interrupt: one SF_TRAP, branches discarded after
        inst(32'h8000_01f0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        inst(32'h8000_01f4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        inst(32'h8000_0200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("trap_fmt", 32'(bus.format_o), 32'd3);
        chk("trap_sub", 32'(bus.subformat_o), 32'd1);
        chk("trap_addr", bus.addr_o, 32'h8000_0200);
        chk("trap_br", 32'(bus.branches_o), 32'd2);
        chk("trap_map", 32'(bus.branch_map_o), 32'h0000_0003);
        chk("trap_irq", 32'(bus.interrupt_o), 32'd1);
        step();
        chk("trap_single", 32'(bus.packet_valid_o), 32'd0);
        inst(32'h8000_0210, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_trap_fmt", 32'(bus.format_o), 32'd2);
        chk("post_trap_br", 32'(bus.branches_o), 32'd0);
        step();

        // Back-pressure: outputs hold while ready is low
        bus.packet_ready_i = 1'b0;
        inst(32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.packet_valid_o), 32'd1);
            chk("bp_stall", 32'(bus.stall_o), 32'd1);
            chk("bp_addr", bus.addr_o, 32'h0000_0300);
            chk("bp_fmt", 32'(bus.format_o), 32'd2);
            step();
        end
        bus.packet_ready_i = 1'b1;
        step();
        chk("bp_acc", 32'(bus.packet_valid_o), 32'd0);
        chk("bp_unstall", 32'(bus.stall_o), 32'd0);
        step();
        chk("bp_once", 32'(bus.packet_valid_o), 32'd0);

        // Disable during HOLD finishes the handshake, then goes quiet
        bus.packet_ready_i = 1'b0;
        inst(32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.enable_i = 1'b0;
        step();
        chk("dis_hold", 32'(bus.packet_valid_o), 32'd1);
        bus.packet_ready_i = 1'b1;
        step();
        chk("dis_acc", 32'(bus.packet_valid_o), 32'd0);
        inst(32'h0000_0500, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("dis_quiet", 32'(bus.packet_valid_o), 32'd0);

        // Reset mid-HOLD drops the request; next packet is SF_SUPPORT again
        bus.packet_ready_i = 1'b0;
        bus.enable_i = 1'b1;
        step();
        step();
        chk("rh_valid", 32'(bus.packet_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rh_drop", 32'(bus.packet_valid_o), 32'd0);
        chk("rh_stall", 32'(bus.stall_o), 32'd0);
        chk("rh_sub_clr", 32'(bus.subformat_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rh_resup", 32'(bus.packet_valid_o), 32'd1);
        chk("rh_fmt", 32'(bus.format_o), 32'd3);
        chk("rh_sub", 32'(bus.subformat_o), 32'd3);
        bus.packet_ready_i = 1'b1;
        step();
        chk("rh_acc", 32'(bus.packet_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/trdb_packet_scheduler.md
TRDB_PACKET_SCHEDULER -- requirements
Module: trdb_packet_scheduler

Interface
REQ-001 SHALL have parameters: XLEN, 32, address width; BMAP_LEN, 31, branch map capacity; RESYNC_MAX, 1024, instructions between periodic resyncs.
REQ-002 SHALL have ports (name direction width meaning):
 clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low;
 enable_i in 1 trace enable; inst_valid_i in 1 instruction retired this cycle; iaddr_i in XLEN retired instruction address;
 is_branch_i in 1 retired inst is conditional branch; branch_taken_i in 1 branch taken;
 exception_i in 1 retired inst trapped; interrupt_i in 1 trap is interrupt; updiscon_i in 1 retired inst is uninferable discontinuity;
 packet_ready_i in 1 emitter accepts request;
 packet_valid_o out 1 request pending; format_o out 2 packet format; subformat_o out 2 F_SYNC subformat;
 addr_o out XLEN address to report; branches_o out 5 valid entries in map; branch_map_o out BMAP_LEN map (bit0 oldest, 1 = not taken);
 interrupt_o out 1 registered interrupt_i; stall_o out 1 upstream must hold retirement.

Function
REQ-003 SHALL use encodings F_OPT_EXT=0, F_DIFF_DELTA=1, F_ADDR_ONLY=2, F_SYNC=3; SF_START=0, SF_TRAP=1, SF_CONTEXT=2, SF_SUPPORT=3.
REQ-004 SHALL implement FSM IDLE, SUPPORT, START, RUN, HOLD.
REQ-005 IDLE: enable_i rising (registered compare) -> SUPPORT; inst_valid_i ignored.
REQ-006 SUPPORT: raise F_SYNC/SF_SUPPORT request the next cycle; on acceptance -> START.
REQ-007 START: first inst_valid_i raises F_SYNC/SF_START with addr_o=iaddr_i, map cleared -> HOLD, then RUN on acceptance.
REQ-008 RUN per inst_valid_i, priority high->low: exception_i -> F_SYNC/SF_TRAP, addr_o=iaddr_i; resync pending -> F_SYNC/SF_START; updiscon_i with branches>0 -> F_DIFF_DELTA with address; updiscon_i with branches==0 -> F_ADDR_ONLY; map full after this inst -> F_DIFF_DELTA, branches_o=31; else no packet.
REQ-009 Branch bit of current instruction SHALL be appended to the map before snapshot, so it is included in any packet raised that cycle.
REQ-010 Any request snapshots format/subformat/addr/branches/map into output registers, clears the live map and counter the same cycle, enters HOLD.
REQ-011 HOLD: packet_valid_o=1, all outputs stable until packet_valid_o && packet_ready_i; stall_o=1 whole HOLD; acceptance -> RUN (or START path per REQ-007); no new request while in HOLD.
REQ-012 Handshake: request visible one cycle after the triggering retirement; zero-wait acceptance gives one packet per two cycles max.
REQ-013 branches counter SHALL saturate at BMAP_LEN, never wrap; full triggers emission per REQ-008.
REQ-014 enable_i falling in any state: if HOLD, complete current handshake first; then -> IDLE, map/counter cleared, no further packets.
REQ-015 F_SYNC packets (START, TRAP) SHALL clear resync pending and restart the resync counter.
REQ-016 Simultaneous exception_i and updiscon_i: single SF_TRAP only; pending branches discarded after snapshot (branches_o reported).

Reset
REQ-017 Reset SHALL force IDLE, packet_valid_o=0, stall_o=0, format_o=0, subformat_o=0, addr_o=0, branches_o=0, branch_map_o=0, interrupt_o=0, resync state cleared.
REQ-018 Reset mid-HOLD SHALL drop the pending request without acceptance; first post-reset packet is SF_SUPPORT.

Configuration
REQ-019 Macro TRDB_RESYNC_TIMER_EN: defined -> counter increments per inst_valid_i in RUN, at RESYNC_MAX sets resync pending; undefined -> counter and pending flag absent, no periodic SF_START.

Verification
REQ-020 enable_i 0->1, ready=1, inst at 0x8000_0000 -> SF_SUPPORT packet, then SF_START addr_o=0x8000_0000.
REQ-021 31 branches in RUN, pattern alternating taken -> F_DIFF_DELTA branches_o=31, map=0x2AAA_AAAA, map then empty.
REQ-022 3 branches then updiscon at 0x8000_0100 -> F_DIFF_DELTA branches_o=4 (incl. REQ-009 rule if branch), addr_o=0x8000_0100; no branches -> F_ADDR_ONLY.
REQ-023 packet_ready_i low 5 cycles during HOLD -> outputs stable, stall_o=1 for 5+ cycles, single acceptance.
REQ-024 With TRDB_RESYNC_TIMER_EN, RESYNC_MAX=8: 8 plain insts then inst at 0x100 -> SF_START addr_o=0x100; without macro -> no packet.
